// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pc, async-read instruction port, in-order fetch queue to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ADDR_W      = 12,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [31:0]       pc,
  output logic              fetch_fault
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      q_pc_q   [QUEUE_DEPTH];
  logic [31:0]      q_pc_d   [QUEUE_DEPTH];
  logic [31:0]      q_inst_q [QUEUE_DEPTH];
  logic [31:0]      q_inst_d [QUEUE_DEPTH];
  logic             pop, push;

  assign inst_addr   = pc_q[ADDR_W+1:2];
  assign pc          = pc_q;
  assign fetch_fault = fault_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = out_valid ? q_pc_q[head_q]   : 32'h0;
  assign out_inst    = out_valid ? q_inst_q[head_q] : 32'h0;

  always_comb begin
    pop      = out_valid & out_ready;
    // A simultaneous pop frees the slot, so a full queue can still accept a push.
    push     = fetch_en & ~fault_q & ~redirect & ((count_q < DEPTH_C) | pop);
    pc_d     = pc_q;
    fault_d  = fault_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else begin
      if (push) begin
        q_pc_d[tail_q]   = pc_q;
        q_inst_d[tail_q] = inst_data;
        tail_d           = tail_q + PTR_W'(1);
        pc_d             = pc_q + 32'd4;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]   <= 32'h0;
        q_inst_q[i] <= 32'h0;
      end
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      q_pc_q   <= q_pc_d;
      q_inst_q <= q_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit with hand-written reset/wrap sequences
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        fetch_en, redirect, out_ready;
  logic [31:0] redirect_pc, inst_data;
  logic [11:0] inst_addr;
  logic        out_valid, fetch_fault;
  logic [31:0] out_pc, out_inst, pc;

  logic [31:0] mem [0:4095];
  assign inst_data = mem[inst_addr];

  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(12), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_addr(inst_addr), .inst_data(inst_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .pc(pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fe, rd, rdy;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] opc, oinst, epc;
    logic        flt;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input logic fe, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic v, input logic [31:0] opc,
                              input logic [31:0] oinst, input logic [31:0] epc, input logic flt);
    vec_t t;
    t.fe = fe; t.rd = rd; t.rpc = rpc; t.rdy = rdy; t.v = v;
    t.opc = opc; t.oinst = oinst; t.epc = epc; t.flt = flt;
    vecs.push_back(t);
  endfunction

  task automatic check_all(input string tag, input logic v, input logic [31:0] opc,
                           input logic [31:0] oinst, input logic [31:0] epc, input logic flt);
    logic [31:0] ea;
    ea = {20'h0, epc[13:2]};
    check({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, v});
    check({tag, ".out_pc"}, out_pc, opc);
    check({tag, ".out_inst"}, out_inst, oinst);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".inst_addr"}, {20'h0, inst_addr}, ea);
    check({tag, ".fetch_fault"}, {31'h0, fetch_fault}, {31'h0, flt});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 | i;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;

    // fe rd rpc rdy | valid out_pc out_inst pc fault
    add(1,0,0,1, 0,32'h00,32'd0,32'h00,0);
    add(1,0,0,1, 1,32'h00,32'd11,32'h04,0);
    add(1,0,0,1, 1,32'h04,32'd22,32'h08,0);
    add(1,0,0,1, 1,32'h08,32'd33,32'h0C,0);
    add(1,0,0,1, 1,32'h0C,32'd44,32'h10,0);
    add(1,1,32'h0,1, 1,32'h10,32'hC000_0004,32'h14,0);
    add(1,0,0,0, 0,32'h00,32'd0,32'h00,0);
    add(1,0,0,0, 1,32'h00,32'd11,32'h04,0);
    add(1,0,0,0, 1,32'h00,32'd11,32'h08,0);
    add(1,0,0,0, 1,32'h00,32'd11,32'h08,0);
    add(1,0,0,0, 1,32'h00,32'd11,32'h08,0);
    add(1,0,0,1, 1,32'h00,32'd11,32'h08,0);
    add(1,0,0,1, 1,32'h04,32'd22,32'h0C,0);
    add(1,0,0,1, 1,32'h08,32'd33,32'h10,0);
    add(1,0,0,0, 1,32'h0C,32'd44,32'h14,0);
    add(1,1,32'h40,1, 1,32'h0C,32'd44,32'h14,0);
    add(1,0,0,1, 0,32'h00,32'd0,32'h40,0);
    add(1,0,0,1, 1,32'h40,32'hC000_0010,32'h44,0);
    add(1,1,32'h42,0, 1,32'h44,32'hC000_0011,32'h48,0);
    add(1,0,0,1, 0,32'h00,32'd0,32'h40,1);
    add(1,0,0,1, 0,32'h00,32'd0,32'h40,1);
    add(1,1,32'h80,1, 0,32'h00,32'd0,32'h40,1);
    add(1,0,0,1, 0,32'h00,32'd0,32'h80,1);

    rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      fetch_en = vecs[i].fe; redirect = vecs[i].rd;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].opc, vecs[i].oinst, vecs[i].epc, vecs[i].flt);
    end

    // Fault clears only on reset.
    @(negedge clk);
    redirect = 1'b0; rst_n = 1'b0;
    #1;
    check_all("fault_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // PC wrap across the 12-bit word address boundary.
    @(negedge clk);
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h3FFC; out_ready = 1'b1; fetch_en = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_all("wrap0", 1'b0, 32'h0, 32'h0, 32'h3FFC, 1'b0);
    @(negedge clk);
    #1;
    check_all("wrap1", 1'b1, 32'h3FFC, 32'hC000_0FFF, 32'h4000, 1'b0);

    // Asynchronous reset with two queued entries.
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check_all("prefill", 1'b1, 32'h3FFC, 32'hC000_0FFF, 32'h4004, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check_all("resume0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    check_all("resume1", 1'b1, 32'h0, 32'd11, 32'h4, 1'b0);
    @(negedge clk);
    #1;
    check_all("resume2", 1'b1, 32'h4, 32'd22, 32'h8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
